// File: rtl/kiss_sched_pkg.sv
// Shared types and constants for the KISS random-word scheduler.
// Generator state layout, reset seed and step constants live here.
package kiss_sched_pkg;

    typedef struct packed {
        logic [31:0] jcong;
        logic [31:0] jsr;
        logic [31:0] w;
        logic [31:0] z;
    } kiss_state_t;

    localparam logic [31:0] ZSeed     = 32'd362436069;
    localparam logic [31:0] WSeed     = 32'd521288629;
    localparam logic [31:0] JsrSeed   = 32'd123456789;
    localparam logic [31:0] JcongSeed = 32'd380116160;

    localparam kiss_state_t KissResetSeed = '{
        jcong: JcongSeed,
        jsr:   JsrSeed,
        w:     WSeed,
        z:     ZSeed
    };

    localparam logic [31:0] MultZ    = 32'd36969;
    localparam logic [31:0] MultW    = 32'd18000;
    localparam logic [31:0] MultCong = 32'd69069;
    localparam logic [31:0] IncCong  = 32'd1234567;

    typedef enum logic {StIdle, StRun} state_e;

endpackage

// File: rtl/kiss_step.sv
// One combinational KISS step: next generator state and the output word.
// All arithmetic wraps at 32 bits.
module kiss_step
    import kiss_sched_pkg::*;
(
    input  kiss_state_t cur,
    output kiss_state_t nxt,
    output logic [31:0] word
);

    logic [31:0] jsr1;
    logic [31:0] jsr2;

    always_comb begin
        nxt.z     = MultZ * {16'h0, cur.z[15:0]} + {16'h0, cur.z[31:16]};
        nxt.w     = MultW * {16'h0, cur.w[15:0]} + {16'h0, cur.w[31:16]};
        jsr1      = cur.jsr ^ (cur.jsr << 17);
        jsr2      = jsr1 ^ (jsr1 >> 13);
        nxt.jsr   = jsr2 ^ (jsr2 << 5);
        nxt.jcong = MultCong * cur.jcong + IncCong;
        word      = (({nxt.z[15:0], 16'h0} + nxt.w) ^ nxt.jcong) + nxt.jsr;
    end

endmodule

// File: rtl/kiss_rng_sched.sv
// KISS random-word engine shared by N_REQ requesters with round-robin grants.
// Each grant streams a burst of words over valid/ready, tagged with the requester id.
module kiss_rng_sched
    import kiss_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     seed_load,
    input  logic [127:0]             seed_data,
    output logic                     seed_ready,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    output logic                     busy
);

    state_e            state_q, state_d;
    kiss_state_t       kiss_q, kiss_d, kiss_nxt;
    logic [31:0]       kiss_word;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              ov_q, ov_d;
    logic [31:0]       od_q, od_d;
    logic [ID_W-1:0]   oid_q, oid_d;
    logic              ol_q, ol_d;

    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    int unsigned       cand;
    logic [LEN_W-1:0]  sel_len;
    logic [LEN_W-1:0]  len_eff;
    logic              advance;
    logic              take_grant;

    kiss_step u_step (
        .cur  (kiss_q),
        .nxt  (kiss_nxt),
        .word (kiss_word)
    );

    // First requesting index strictly after rr_q, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(rr_q) + k) % N_REQ;
            if (!grant_any && req_valid[ID_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    always_comb begin
        sel_len = req_len[32'(grant_idx) * LEN_W +: LEN_W];
        len_eff = (32'(sel_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : sel_len;
    end

    assign advance    = !ov_q || out_ready;
    assign take_grant = (state_q == StIdle) && !seed_load && grant_any;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_grant && len_eff != '0) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (advance && rem_q == '0) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        seed_ready = 1'b0;
        req_ready  = '0;
        busy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                seed_ready = 1'b1;
                if (take_grant) begin
                    req_ready = N_REQ'(1) << grant_idx;
                end
            end
            StRun: begin
                busy = 1'b1;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        kiss_d = kiss_q;
        rr_d   = rr_q;
        id_d   = id_q;
        rem_d  = rem_q;
        ov_d   = ov_q;
        od_d   = od_q;
        oid_d  = oid_q;
        ol_d   = ol_q;
        unique case (state_q)
            StIdle: begin
                if (seed_load) begin
                    kiss_d = kiss_state_t'(seed_data);
                end else if (grant_any) begin
                    rr_d  = grant_idx;
                    id_d  = grant_idx;
                    rem_d = len_eff;
                end
            end
            StRun: begin
                if (advance) begin
                    if (rem_q != '0) begin
                        kiss_d = kiss_nxt;
                        od_d   = kiss_word;
                        ov_d   = 1'b1;
                        oid_d  = id_q;
                        ol_d   = (rem_q == LEN_W'(1));
                        rem_d  = rem_q - LEN_W'(1);
                    end else begin
                        ov_d = 1'b0;
                        ol_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kiss_q <= KissResetSeed;
            rr_q   <= ID_W'(N_REQ - 1);
            id_q   <= '0;
            rem_q  <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            oid_q  <= '0;
            ol_q   <= 1'b0;
        end else begin
            kiss_q <= kiss_d;
            rr_q   <= rr_d;
            id_q   <= id_d;
            rem_q  <= rem_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            oid_q  <= oid_d;
            ol_q   <= ol_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_id    = oid_q;
    assign out_last  = ol_q;

endmodule

// File: doc/kiss_rng_sched.md
Name: kiss_rng_sched

Overview:
- Sequential KISS (Marsaglia z/w/jsr/jcong) random-word engine, shared between N_REQ requesters under round-robin arbitration.
- Each granted request is a burst of 1..MAX_LEN 32-bit words, streamed one word per cycle over a valid/ready output, tagged with the requester id.
- It is the hardware scheduler for the KISS generator used by the exe_env flow; state words are seedable between bursts.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- MAX_LEN, 16, maximum words per burst.
- LEN_W, $clog2(MAX_LEN+1), width of a burst length field.
- ID_W, $clog2(N_REQ), width of the requester id.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  load seed_data into the generator state.
- seed_data  in  128  {jcong, jsr, w, z}; z is bits [31:0].
- seed_ready  out  1  seed accepted this cycle when seed_load & seed_ready.
- req_valid  in  N_REQ  per-requester burst request.
- req_len  in  N_REQ*LEN_W  per-requester length; slice i is [i*LEN_W +: LEN_W].
- req_ready  out  N_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  32  KISS word.
- out_id  out  ID_W  requester owning out_data.
- out_last  out  1  final word of the burst.
- busy  out  1  state is RUN.

Behaviour:
- Reset values: state=IDLE, z=362436069, w=521288629, jsr=123456789, jcong=380116160, rr_ptr=N_REQ-1, remaining count=0, all outputs 0.
  - seed_ready is 1 after reset (IDLE, no request pending).
- Step function (one word), all arithmetic mod 2^32:
  - z'=36969*(z&65535)+(z>>16)
  - w'=18000*(w&65535)+(w>>16)
  - jsr1=jsr^(jsr<<17); jsr2=jsr1^(jsr1>>13); jsr'=jsr2^(jsr2<<5)
  - jcong'=69069*jcong+1234567
  - A=(((z'<<16)+w')^jcong')+jsr'
- IDLE:
  - seed_ready=1. seed_load has priority over requests: on seed_load, the four state registers load next edge and req_ready=0 that cycle.
  - Otherwise, if any req_valid, grant the first set bit searching from rr_ptr+1 upward with wrap. req_ready is combinational from req_valid/rr_ptr.
  - On grant: rr_ptr<=winner, latch id; len_eff = min(req_len, MAX_LEN).
    - len_eff=0: request consumed, no output, stay IDLE.
    - Else: remaining<=len_eff, go to RUN.
- RUN:
  - seed_ready=0; req_ready=0; busy=1.
  - When !out_valid or out_ready: apply step, out_data<=A, out_valid<=1, out_id<=id, out_last<=(remaining==1), remaining<=remaining-1.
  - When out_valid & !out_ready: hold all outputs and generator state stable (no step).
  - When the last word is accepted and remaining==0: out_valid<=0, out_last<=0, go to IDLE.
- Latency: grant accepted at edge T; first out_valid at edge T+1. Throughput is 1 word/cycle under continuous out_ready.
- The next grant is evaluated in the IDLE cycle after the last word handshake, so there is one bubble cycle between bursts.
- The generator state persists across bursts and requesters: the sequence is continuous, and only seed_load or reset changes it.
- Async reset mid-burst: immediate return to reset values, burst discarded, no out_last.
- A requester dropping req_valid without a grant is legal; no state change.

Decomposition:
- Package kiss_sched_pkg holds:
  - typedef kiss_state_t (packed {jcong, jsr, w, z}, 32 bits each);
  - the reset-seed constants;
  - the multiplier and increment constants 36969, 18000, 69069, 1234567;
  - the state enum {IDLE, RUN}.
- One natural sub-module: kiss_step, purely combinational. It maps kiss_state_t to the next kiss_state_t plus the 32-bit word A.
- Round-robin pick stays inline.

Test Plan:
- Seed all-zero, req0 len=2, out_ready=1 -> words 1234567 then 3667164066, out_id=0, out_last on word 2, out_valid first high one cycle after grant.
- req_valid=4'b1111, each len=1, rr_ptr from reset -> grant order 0,1,2,3,0; exactly one req_ready bit per IDLE grant.
- out_ready toggling 1,0,0,1 during len=4 burst -> out_data/out_last stable while stalled; sequence identical to the unstalled golden model.
- req_len=0 on req2 -> req_ready[2] pulses, no out_valid, rr_ptr=2; req_len=31 (MAX_LEN=16) -> exactly 16 words.
- seed_load during RUN ignored (seed_ready=0), applied when IDLE. Same-cycle seed_load with req_valid -> seed wins, grant next cycle.
- rst_n low mid-burst -> out_valid=0 asynchronously; after release, first word equals the reset-seed golden first word.
